// File: rtl/sig_xy_row_accum_if.sv
// Bundles the product-beat input, the upstream stall and the row-result output of sig_xy_row_accum.
// slave = the accumulator itself, master = the producer/consumer environment driving it.
interface sig_xy_row_accum_if #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int SUM_WIDTH       = 16 + $clog2(IMAGE_DIM)
);
    localparam int ROW_W = $clog2(IMAGE_DIM);

    logic                    in_valid;
    logic [2*DATA_WIDTH-1:0] in_prod;
    logic                    stall;
    logic [SUM_WIDTH-1:0]    out_sum;
    logic [ROW_W-1:0]        out_row;
    logic                    out_last;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_valid, in_prod, out_ready,
        input  stall, out_sum, out_row, out_last, out_valid
    );

    modport slave (
        input  in_valid, in_prod, out_ready,
        output stall, out_sum, out_row, out_last, out_valid
    );
endinterface

// File: rtl/sig_xy_row_accum.sv
// Row accumulator for x*y product beats: pipelined adder tree, per-row accumulation, one tagged sum per row.
// Define SIG_XY_MEAN_EN to emit the row mean (sum >> log2(IMAGE_DIM)) instead of the full row sum.
module sig_xy_row_accum #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int SUM_WIDTH       = 16 + $clog2(IMAGE_DIM)
) (
    input  logic                clk,
    input  logic                aresetn,
    sig_xy_row_accum_if.slave   bus
);
    localparam int LEVELS        = $clog2(PIXELS_PER_BEAT);
    localparam int TREE_W        = 16 + LEVELS;
    localparam int SPLIT         = (LEVELS < 2) ? LEVELS : 2;
    localparam int P1_N          = PIXELS_PER_BEAT >> SPLIT;
    localparam int VEC_W         = PIXELS_PER_BEAT * TREE_W;
    localparam int BEATS_PER_ROW = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int BEAT_W        = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
    localparam int ROW_W         = $clog2(IMAGE_DIM);

    // One adder-tree level: the first n/2 slots receive pairwise sums, the rest are cleared.
    function automatic logic [VEC_W-1:0] reduce_level(input logic [VEC_W-1:0] v, input int n);
        logic [VEC_W-1:0] r;
        r = '0;
        for (int i = 0; i < PIXELS_PER_BEAT / 2; i++) begin
            if (i < n / 2) begin
                r[i*TREE_W +: TREE_W] = v[(2*i)*TREE_W +: TREE_W] + v[(2*i+1)*TREE_W +: TREE_W];
            end
        end
        return r;
    endfunction

    function automatic logic [SUM_WIDTH-1:0] row_result(input logic [SUM_WIDTH-1:0] s);
`ifdef SIG_XY_MEAN_EN
        return s >> ROW_W;
`else
        return s;
`endif
    endfunction

    logic [2*DATA_WIDTH-1:0]  prod;
    logic                     advance;

    logic [VEC_W-1:0]         lvl_in;
    logic [VEC_W-1:0]         lvl_s1;
    logic [VEC_W-1:0]         lvl_s2;
    logic [P1_N*TREE_W-1:0]   sum_p1_d, sum_p1_q;
    logic [TREE_W-1:0]        sum_p2_d, sum_p2_q;
    logic                     vld_p1_q, vld_p2_q;

    logic [SUM_WIDTH-1:0]     acc_d, acc_q;
    logic [SUM_WIDTH-1:0]     row_total;
    logic [BEAT_W-1:0]        beat_cnt_d, beat_cnt_q;
    logic [ROW_W-1:0]         row_cnt_d, row_cnt_q;
    logic                     first_beat, last_beat, last_row;
    logic                     acc_step, load;

    logic [SUM_WIDTH-1:0]     out_sum_d, out_sum_q;
    logic [ROW_W-1:0]         out_row_d, out_row_q;
    logic                     out_last_d, out_last_q;
    logic                     out_valid_d, out_valid_q;

    assign prod      = bus.in_prod;
    assign bus.stall = out_valid_q & ~bus.out_ready;
    assign advance   = ~bus.stall;

    // Stage p1: tree levels 1..SPLIT on the incoming beat
    always_comb begin
        lvl_in = '0;
        for (int j = 0; j < PIXELS_PER_BEAT; j++) begin
            lvl_in[j*TREE_W +: TREE_W] = TREE_W'(prod[j*16 +: 16]);
        end
        lvl_s1 = lvl_in;
        for (int l = 0; l < SPLIT; l++) begin
            lvl_s1 = reduce_level(lvl_s1, PIXELS_PER_BEAT >> l);
        end
        sum_p1_d = lvl_s1[P1_N*TREE_W-1:0];
    end

    // Stage p2: remaining tree levels down to a single beat sum
    always_comb begin
        lvl_s2 = '0;
        lvl_s2[P1_N*TREE_W-1:0] = sum_p1_q;
        for (int l = 0; l < LEVELS - SPLIT; l++) begin
            lvl_s2 = reduce_level(lvl_s2, P1_N >> l);
        end
        sum_p2_d = lvl_s2[TREE_W-1:0];
    end

    // Accumulate/output stage: the completed row total goes straight into the output register
    always_comb begin
        first_beat = (beat_cnt_q == '0);
        last_beat  = (beat_cnt_q == BEAT_W'(BEATS_PER_ROW - 1));
        last_row   = (row_cnt_q == ROW_W'(IMAGE_DIM - 1));
        acc_step   = vld_p2_q & advance;
        load       = acc_step & last_beat;
        row_total  = (first_beat ? '0 : acc_q) + SUM_WIDTH'(sum_p2_q);

        acc_d      = acc_step ? row_total : acc_q;
        beat_cnt_d = beat_cnt_q;
        if (acc_step) begin
            beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
        end
        row_cnt_d  = row_cnt_q;
        if (load) begin
            row_cnt_d = last_row ? '0 : row_cnt_q + 1'b1;
        end

        out_sum_d   = out_sum_q;
        out_row_d   = out_row_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_sum_d   = row_result(row_total);
            out_row_d   = row_cnt_q;
            out_last_d  = last_row;
            out_valid_d = 1'b1;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vld_p1_q    <= 1'b0;
            sum_p1_q    <= '0;
            vld_p2_q    <= 1'b0;
            sum_p2_q    <= '0;
            acc_q       <= '0;
            beat_cnt_q  <= '0;
            row_cnt_q   <= '0;
            out_sum_q   <= '0;
            out_row_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (advance) begin
                vld_p1_q <= bus.in_valid;
                sum_p1_q <= sum_p1_d;
                vld_p2_q <= vld_p1_q;
                sum_p2_q <= sum_p2_d;
            end
            acc_q       <= acc_d;
            beat_cnt_q  <= beat_cnt_d;
            row_cnt_q   <= row_cnt_d;
            out_sum_q   <= out_sum_d;
            out_row_q   <= out_row_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.out_sum   = out_sum_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sig_xy_row_accum.sv
// Directed bench for sig_xy_row_accum: row sums, latency, backpressure, frame wrap, async reset.
module tb_sig_xy_row_accum;
    localparam int PPB = 16;
    localparam int DIM = 512;
    localparam int SW  = 25;
    localparam int RW  = 9;
    localparam int PW  = 2 * 8 * PPB;
    localparam int BPR = DIM / PPB;

    logic clk = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    sig_xy_row_accum_if #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM)) bus ();

    sig_xy_row_accum #(.PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    typedef struct {
        logic [SW-1:0] sum;
        logic [RW-1:0] row;
        logic          last;
        int            cyc;
    } res_t;

    res_t q[$];
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;
    int   last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Each low phase with valid&ready is exactly one transfer at the following edge
    always @(negedge clk) begin
        if (aresetn && bus.out_valid && bus.out_ready)
            q.push_back('{bus.out_sum, bus.out_row, bus.out_last, cyc});
    end

    function automatic int expv(input int s);
`ifdef SIG_XY_MEAN_EN
        return s >> 9;
`else
        return s;
`endif
    endfunction

    function automatic logic [PW-1:0] fill(input logic [15:0] v);
        logic [PW-1:0] r;
        for (int j = 0; j < PPB; j++) r[j*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [PW-1:0] ramp();
        logic [PW-1:0] r;
        for (int j = 0; j < PPB; j++) r[j*16 +: 16] = 16'(j + 1);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [PW-1:0] p);
        bit acc;
        int w;
        acc = 1'b0;
        w = 0;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        while (!acc && w < 200) begin
            @(negedge clk);
            acc = !bus.stall;
            if (acc) last_acc = cyc;
            @(posedge clk);
            #1;
            w++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_row(input logic [PW-1:0] p);
        for (int b = 0; b < BPR; b++) send_beat(p);
    endtask

    task automatic expect_row(input string tag, input int esum, input int erow,
                              input bit elast, input bit chk_lat);
        res_t r;
        n_assert++;
        assert (q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_present: observed 0 results expected 1", tag);
        end
        if (q.size() > 0) begin
            r = q.pop_front();
            chk({tag, "_sum"}, 32'(r.sum), expv(esum));
            chk({tag, "_row"}, 32'(r.row), erow);
            chk({tag, "_last"}, 32'(r.last), 32'(elast));
            if (chk_lat) chk({tag, "_lat"}, r.cyc, last_acc + 3);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 0);
        chk("rst_sum",   32'(bus.out_sum), 0);
        chk("rst_row",   32'(bus.out_row), 0);
        chk("rst_last",  32'(bus.out_last), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;

        // All lanes 1, continuous, with latency check
        send_row(fill(16'd1));
        idle(6);
        expect_row("ones", 512, 0, 1'b0, 1'b1);

        // All lanes at maximum
        send_row(fill(16'hFFFF));
        idle(6);
        expect_row("max", 33553920, 1, 1'b0, 1'b1);

        // Ramp row with downstream backpressure; next row's first beats sit in the pipeline
        bus.out_ready = 1'b0;
        send_row(ramp());
        send_beat(ramp());
        send_beat(ramp());
        bus.in_prod = ramp();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_stall", 32'(bus.stall), 1);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_sum",   32'(bus.out_sum), expv(4352));
            chk("bp_row",   32'(bus.out_row), 2);
            @(posedge clk);
            #1;
        end
        chk("bp_held", q.size(), 0);
        bus.out_ready = 1'b1;
        for (int b = 2; b < BPR; b++) send_beat(ramp());
        idle(6);
        expect_row("ramp0", 4352, 2, 1'b0, 1'b0);
        expect_row("ramp1", 4352, 3, 1'b0, 1'b0);

        // Two rows of 2 with input bubbles
        for (int b = 0; b < 2 * BPR; b++) begin
            send_beat(fill(16'd2));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(6);
        expect_row("gap0", 1024, 4, 1'b0, 1'b0);
        expect_row("gap1", 1024, 5, 1'b0, 1'b0);

        // Full frame of 1: rows 6..511 then wrap to 0..5
        for (int r = 0; r < DIM; r++) send_row(fill(16'd1));
        idle(6);
        chk("frame_count", q.size(), DIM);
        for (int k = 0; k < DIM; k++) begin
            int er;
            er = (6 + k) % DIM;
            expect_row("frame", 512, er, er == DIM - 1, 1'b0);
        end

        // Async reset in the middle of a row
        for (int b = 0; b < 10; b++) send_beat(fill(16'd1));
        bus.in_valid = 1'b0;
        #3;
        aresetn = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 0);
        chk("arst_sum",   32'(bus.out_sum), 0);
        chk("arst_row",   32'(bus.out_row), 0);
        chk("arst_last",  32'(bus.out_last), 0);
        chk("arst_stall", 32'(bus.stall), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_noresult", q.size(), 0);
        send_row(fill(16'd1));
        idle(6);
        expect_row("post_rst", 512, 0, 1'b0, 1'b1);
        chk("post_rst_extra", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/sig_xy_row_accum.md
Name: sig_xy_row_accum

Overview:
- Downstream consumer of the per-pixel x*y product beats (PIXELS_PER_BEAT 16-bit products per beat).
- Reduces each beat through a pipelined adder tree, then accumulates beats across one image row (IMAGE_DIM pixels).
- Emits one row sum per row, tagged with the row index and an end-of-frame flag.
- Feeds the sigma_xy statistics path; generates the upstream stall from downstream backpressure.

Parameters:
PIXELS_PER_BEAT, 16, products per input beat (power of 2)
IMAGE_DIM, 512, pixels per row and rows per frame (power of 2, multiple of PIXELS_PER_BEAT)
DATA_WIDTH, 8*PIXELS_PER_BEAT, width of one upstream pixel beat; product bus is 2*DATA_WIDTH
SUM_WIDTH, 16+$clog2(IMAGE_DIM), row-sum width (25 at defaults)

Ports:
clk  in  1  clock
aresetn  in  1  asynchronous active-low reset
in_valid  in  1  product beat present
in_prod  in  2*DATA_WIDTH  packed unsigned 16-bit products; lane j = [j*16 +:16]
stall  out  1  upstream hold; beat not accepted while high
out_sum  out  SUM_WIDTH  row sum of products (see SIG_XY_MEAN_EN)
out_row  out  $clog2(IMAGE_DIM)  row index of out_sum
out_last  out  1  out_sum is last row of frame
out_valid  out  1  output holds a valid row result
out_ready  in  1  downstream accepts output

Behaviour:
- One clock, asynchronous active-low reset (aresetn).
- Reset clears all registers:
  - out_valid=0, out_sum=0, out_row=0, out_last=0.
  - Pipeline valid bits=0, beat counter=0, row counter=0, accumulator=0.
- stall = out_valid & ~out_ready (combinational).
- advance = ~stall. Every pipeline register, counter and the accumulator update only when advance=1; all are frozen otherwise.
- Beat accepted when in_valid & advance.
- Adder tree, unsigned, lossless widths:
  - Level widths are 17/18/19/20 bits; $clog2(PIXELS_PER_BEAT) levels.
  - Stage S1 register after level 2; stage S2 register after the final level. Each stage carries a valid bit.
- Accumulator stage, on S2 valid with advance:
  - First beat of row (beat_cnt==0): acc = tree_sum.
  - Otherwise: acc = acc + tree_sum.
  - beat_cnt wraps at IMAGE_DIM/PIXELS_PER_BEAT-1 (31 at defaults).
- On the last beat of a row, with advance:
  - Load out_sum with the completed row sum, out_row=row_cnt, out_last=(row_cnt==IMAGE_DIM-1); set out_valid=1.
  - row_cnt increments, wrapping IMAGE_DIM-1 -> 0.
- Latency: final beat of a row accepted at cycle t -> out_valid high at cycle t+3 (no stall in between).
- out_valid clears on out_valid & out_ready, unless a new result loads the same cycle (then it stays 1 with new data).
- No overwrite is possible: a load requires advance, which implies out_valid=0 or out_ready=1.
- Bubbles (in_valid=0): no count change; pipeline valid bits propagate 0.
- Max sum IMAGE_DIM*65535 fits SUM_WIDTH exactly; no saturation logic.
- Reset mid-row: partial row discarded; next accepted beat is beat 0 of row 0.
- out_* stable while out_valid & ~out_ready.

Optional Feature:
SIG_XY_MEAN_EN
- Defined:
  - out_sum carries the row mean = row sum >> $clog2(IMAGE_DIM), truncated.
  - Upper SUM_WIDTH-16 bits of out_sum are zero.
  - Shift is registered into the output stage; latency unchanged.
- Undefined: out_sum carries the full row sum.

Test Plan:
- All lanes =1, in_valid continuous, out_ready=1, 32 beats -> out_valid at 3 cycles after last beat; out_sum=512, out_row=0, out_last=0.
- All lanes =0xFFFF for one row -> out_sum=33553920 (with SIG_XY_MEAN_EN: 65535).
- Lane j = j+1, 32 beats, out_ready held low 10 cycles after out_valid:
  - out_sum=4352.
  - stall high throughout; output and pipeline frozen.
  - No beat lost: next row sum also correct after out_ready=1.
- Random in_valid gaps (~50% duty) over 2 rows of constant 2 -> sums 1024, 1024; out_row 0 then 1.
- Full frame of constant 1 -> 512 results:
  - out_last high only on out_row=511.
  - Next result has out_row=0.
- aresetn pulsed low after beat 10 of a row (async, mid-cycle):
  - All outputs 0 immediately.
  - Subsequent 32 beats of 1 produce out_sum=512, out_row=0.
